// File: rtl/ioctl_loader_bridge_if.sv
// ioctl_loader_bridge_if: bundles the hps_io download stream and the core
// loader port. The bridge connects as slave. hps_io and the core loader side
// connect as master.
interface ioctl_loader_bridge_if #(
  parameter int unsigned AW          = 19,
  parameter int unsigned DW          = 8,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned RW          = 2
);
  // hps_io side
  logic                   ioctl_download;
  logic [7:0]             ioctl_index;
  logic                   ioctl_wr;
  logic [24:0]            ioctl_addr;
  logic [DW-1:0]          ioctl_dout;
  logic                   ioctl_wait;
  // core loader side
  logic [AW-1:0]          ldr_adr;
  logic [RW-1:0]          ldr_region;
  logic [DW-1:0]          ldr_wdat;
  logic                   ldr_wr;
  logic                   ldr_ack;
  logic                   ldr_oe;
  logic [NUM_REGIONS-1:0] ldr_done;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_adr, ldr_region, ldr_wdat, ldr_wr, ldr_oe, ldr_done
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_adr, ldr_region, ldr_wdat, ldr_wr, ldr_oe, ldr_done
  );
endinterface

// File: rtl/ioctl_loader_bridge.sv
// ioctl_loader_bridge: buffers HPS ioctl download bytes in a small FIFO and
// replays them to the core loader port one acknowledged write at a time.
// Tracks a done flag per region and releases the core once the first
// download starts.
// Optional: define LOADER_CHECKSUM_EN to add per-region 16-bit additive sums
// (csum_sel / csum ports).
module ioctl_loader_bridge #(
  parameter int unsigned AW          = 19,
  parameter int unsigned DW          = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned RW          = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  ioctl_loader_bridge_if.slave bus,
  output logic                 core_rst_n,
  output logic                 idx_err
`ifdef LOADER_CHECKSUM_EN
  ,
  input  logic [RW-1:0]        csum_sel,
  output logic [15:0]          csum
`endif
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = RW + AW + DW;
  localparam logic [PW:0] CntFull = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CntWarn = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e                 state_q;
  logic                   dl_q, old_ack_q, pend_q;
  logic [7:0]             cur_idx_q, pend_idx_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PW:0]            count_q;
  logic                   ldr_wr_q, wait_q, core_rst_n_q, idx_err_q;
  logic [AW-1:0]          adr_q;
  logic [RW-1:0]          region_q;
  logic [DW-1:0]          wdat_q;
  logic [NUM_REGIONS-1:0] done_q;

  logic       dl_rise, dl_fall, ack_rise, idx_valid, full, wr_load, push, pop, drained;
  logic       start_load, start_valid, finish, wr_done;
  logic [7:0] start_idx;
  logic       unused_addr;

  assign dl_rise     = bus.ioctl_download & ~dl_q;
  assign dl_fall     = ~bus.ioctl_download & dl_q;
  assign ack_rise    = bus.ldr_ack & ~old_ack_q;
  assign idx_valid   = 32'(cur_idx_q) < NUM_REGIONS;
  assign full        = count_q == CntFull;
  assign wr_load     = bus.ioctl_wr & (state_q == StLoad);
  assign push        = wr_load & idx_valid & ~full;
  assign pop         = ~ldr_wr_q & (count_q != '0);
  assign drained     = (count_q == '0) & ~ldr_wr_q;
  assign wr_done     = ldr_wr_q & ack_rise;
  // A download that restarted during DRAIN is remembered in pend_q/pend_idx_q.
  assign start_idx   = pend_q ? pend_idx_q : bus.ioctl_index;
  assign start_load  = (state_q == StIdle) & (dl_rise | pend_q);
  assign start_valid = 32'(start_idx) < NUM_REGIONS;
  assign finish      = (state_q == StDrain) & drained;
  // Address bits above AW are dropped on purpose.
  assign unused_addr = ^bus.ioctl_addr[24:AW];

  // Download sequencing, per-region done flags, back-pressure and sticky status.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      dl_q         <= 1'b0;
      pend_q       <= 1'b0;
      cur_idx_q    <= '0;
      pend_idx_q   <= '0;
      done_q       <= '0;
      wait_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      idx_err_q    <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (dl_rise) core_rst_n_q <= 1'b1;
      if (wr_load && (!idx_valid || full)) idx_err_q <= 1'b1;
      // Based on last cycle's count, leaving one slot for a strobe in flight.
      wait_q <= (count_q >= CntWarn) | pend_q | ((state_q == StDrain) & dl_rise);
      unique case (state_q)
        StIdle: begin
          if (start_load) begin
            state_q   <= StLoad;
            cur_idx_q <= start_idx;
            pend_q    <= 1'b0;
            if (start_valid) done_q[start_idx[RW-1:0]] <= 1'b0;
          end
        end
        StLoad: begin
          if (dl_fall) state_q <= StDrain;
        end
        StDrain: begin
          if (dl_rise) begin
            pend_q     <= 1'b1;
            pend_idx_q <= bus.ioctl_index;
          end
          if (finish) begin
            state_q <= StIdle;
            if (idx_valid) done_q[cur_idx_q[RW-1:0]] <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy, plus the held loader write request.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ldr_wr_q  <= 1'b0;
      adr_q     <= '0;
      region_q  <= '0;
      wdat_q    <= '0;
      old_ack_q <= 1'b0;
    end else begin
      old_ack_q <= bus.ldr_ack;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q                   <= rd_ptr_q + 1'b1;
        {region_q, adr_q, wdat_q}  <= mem_q[rd_ptr_q];
        ldr_wr_q                   <= 1'b1;
      end else if (wr_done) begin
        ldr_wr_q <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= {cur_idx_q[RW-1:0], bus.ioctl_addr[AW-1:0], bus.ioctl_dout};
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.ldr_adr    = adr_q;
  assign bus.ldr_region = region_q;
  assign bus.ldr_wdat   = wdat_q;
  assign bus.ldr_wr     = ldr_wr_q;
  assign bus.ldr_oe     = (state_q != StIdle) | (count_q != '0);
  assign bus.ldr_done   = done_q;
  assign core_rst_n     = core_rst_n_q;
  assign idx_err        = idx_err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q [NUM_REGIONS];

  // Per-region running sum of acknowledged data, cleared with the done flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) sum_q[i] <= '0;
    end else begin
      if (wr_done) sum_q[region_q] <= sum_q[region_q] + 16'(wdat_q);
      if (start_load && start_valid) sum_q[start_idx[RW-1:0]] <= '0;
    end
  end

  assign csum = (32'(csum_sel) < NUM_REGIONS) ? sum_q[csum_sel] : '0;
`endif
endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// tb_ioctl_loader_bridge: scoreboard bench. Stimulus pushes expected loader
// writes into a queue; a monitor pops and compares on every new ldr_wr.
`timescale 1ns/1ps
module tb_ioctl_loader_bridge;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned NR = 4;
  localparam int unsigned RW = 2;
  localparam int unsigned EW = RW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  logic core_rst_n, idx_err;
`ifdef LOADER_CHECKSUM_EN
  logic [RW-1:0] csum_sel;
  logic [15:0]   csum;
`endif

  ioctl_loader_bridge_if #(.AW(AW), .DW(DW), .NUM_REGIONS(NR), .RW(RW)) bus ();

  ioctl_loader_bridge #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .NUM_REGIONS(NR), .RW(RW)
  ) dut (
    .clk_sys    (clk),
    .reset      (rst),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .idx_err    (idx_err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum_sel   (csum_sel),
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [EW-1:0] exp_q [$];
  logic [NR-1:0] exp_done;
  logic          exp_err, exp_rst;
  logic [15:0]   exp_sum [NR];
  logic [7:0]    cur_idx;
  int            ack_dly;
  bit            ack_en;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expired(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired waiting on DUT, got timeout, expected event", name);
  endtask

  // Reference model: what a download of region idx must eventually produce.
  function automatic void model_start(input logic [7:0] idx);
    cur_idx = idx;
    exp_rst = 1'b1;
    if (idx < NR) begin
      exp_done[idx[RW-1:0]] = 1'b0;
      exp_sum[idx[RW-1:0]]  = 16'h0;
    end
  endfunction

  function automatic void model_byte(input logic [24:0] a, input logic [7:0] d);
    if (cur_idx < NR) begin
      exp_q.push_back({cur_idx[RW-1:0], a[AW-1:0], d});
      exp_sum[cur_idx[RW-1:0]] = exp_sum[cur_idx[RW-1:0]] + 16'(d);
    end else begin
      exp_err = 1'b1;
    end
  endfunction

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    model_start(idx);
    repeat (2) @(negedge clk);
  endtask

  // One byte strobe, honouring ioctl_wait; last=1 drops download in the same cycle.
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit last);
    int n = 0;
    while (bus.ioctl_wait === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) expired("ioctl_wait_release");
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (last) bus.ioctl_download = 1'b0;
    model_byte(a, d);
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic finish_dl(input string name);
    int n = 0;
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    while (bus.ldr_oe !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) expired({name, "_drain"});
    if (cur_idx < NR) exp_done[cur_idx[RW-1:0]] = 1'b1;
    chk({name, "_done"}, 32'(bus.ldr_done), 32'(exp_done));
    chk({name, "_idx_err"}, 32'(idx_err), 32'(exp_err));
    chk({name, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_rst));
    chk({name, "_unwritten_bytes"}, exp_q.size(), 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic chk_sums(input string name);
    for (int r = 0; r < NR; r++) begin
      csum_sel = RW'(r);
      #0.5;
      chk(name, 32'(csum), 32'(exp_sum[r]));
    end
  endtask
`endif

  // Core-side responder: ack after ack_dly cycles (random 0..3 when negative).
  initial begin
    int d;
    bus.ldr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ldr_wr === 1'b1 && !bus.ldr_ack && ack_en) begin
        d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        repeat (d) @(negedge clk);
        bus.ldr_ack = 1'b1;
      end else if (bus.ldr_ack && bus.ldr_wr !== 1'b1) begin
        bus.ldr_ack = 1'b0;
      end
    end
  end

  // Monitor: each new write request must match the oldest expected byte.
  initial begin
    logic [EW-1:0] e;
    logic          prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ldr_wr === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          expired("unexpected_ldr_wr");
        end else begin
          e = exp_q.pop_front();
          chk("ldr_write", 32'({bus.ldr_region, bus.ldr_adr, bus.ldr_wdat}), 32'(e));
        end
      end
      prev = bus.ldr_wr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    ack_en             = 1'b1;
    ack_dly            = 2;
    exp_done           = '0;
    exp_err            = 1'b0;
    exp_rst            = 1'b0;
    cur_idx            = '0;
    for (int r = 0; r < NR; r++) exp_sum[r] = '0;
`ifdef LOADER_CHECKSUM_EN
    csum_sel = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ldr_wr", 32'(bus.ldr_wr), 0);
    chk("reset_ldr_oe", 32'(bus.ldr_oe), 0);
    chk("reset_ldr_done", 32'(bus.ldr_done), 0);
    chk("reset_core_rst_n", 32'(core_rst_n), 0);
    chk("reset_idx_err", 32'(idx_err), 0);
    chk("reset_ioctl_wait", 32'(bus.ioctl_wait), 0);

    // Three bytes to region 0, fixed two-cycle ack.
    start_dl(8'd0);
    chk("load_ldr_oe", 32'(bus.ldr_oe), 1);
    strobe(25'd0, 8'h11, 1'b0);
    strobe(25'd1, 8'h22, 1'b0);
    strobe(25'd2, 8'h33, 1'b0);
    finish_dl("basic");
    chk("basic_oe_idle", 32'(bus.ldr_oe), 0);

    // Back-pressure: ack held low, five bytes fill write slot plus FIFO.
    ack_en = 1'b0;
    start_dl(8'd1);
    for (int i = 0; i < 5; i++) strobe(25'(10 + i), 8'($urandom), 1'b0);
    chk("bp_ioctl_wait", 32'(bus.ioctl_wait), 1);
    chk("bp_ldr_wr_held", 32'(bus.ldr_wr), 1);
    ack_en  = 1'b1;
    ack_dly = -1;
    strobe(25'd15, 8'($urandom), 1'b0);
    finish_dl("backpressure");

    // Out-of-range index: bytes discarded, sticky error.
    start_dl(8'd7);
    strobe(25'd0, 8'hA5, 1'b0);
    strobe(25'd1, 8'h5A, 1'b0);
    finish_dl("bad_index");

    // Re-download region 1: its done flag drops at the start.
    start_dl(8'd1);
    chk("reload_done_cleared", 32'(bus.ldr_done), 32'(exp_done));
    for (int i = 0; i < 4; i++) strobe(25'($urandom), 8'($urandom), i == 3);
    finish_dl("reload");

    // New download while region 2 is still draining.
    ack_en = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 3; i++) strobe(25'(100 + i), 8'($urandom), 1'b0);
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
    bus.ioctl_index    = 8'd3;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    chk("restart_ioctl_wait", 32'(bus.ioctl_wait), 1);
    exp_done[2] = 1'b1;
    model_start(8'd3);
    ack_en = 1'b1;
    begin
      int n = 0;
      while (bus.ioctl_wait === 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) expired("restart_wait_release");
    end
    chk("restart_done", 32'(bus.ldr_done), 32'(exp_done));
    chk("restart_ldr_oe", 32'(bus.ldr_oe), 1);
    for (int i = 0; i < 3; i++) strobe(25'(200 + i), 8'($urandom), 1'b0);
    finish_dl("restart");

    // Randomised downloads, some with an invalid index or a last byte on the fall.
    for (int t = 0; t < 8; t++) begin
      logic [7:0] idx;
      int         nb;
      idx = 8'($urandom_range(0, 5));
      nb  = int'($urandom_range(1, 8));
      start_dl(idx);
      for (int i = 0; i < nb; i++) strobe(25'($urandom), 8'($urandom), (i == nb - 1) && t[0]);
      finish_dl("random");
    end

`ifdef LOADER_CHECKSUM_EN
    start_dl(8'd2);
    for (int i = 0; i < 300; i++) strobe(25'(i), 8'hFF, 1'b0);
    finish_dl("csum_load");
    csum_sel = 2'd2;
    #0.5;
    chk("csum_region2", 32'(csum), 32'h2AD4);
    chk_sums("csum_model");
`endif

    // Reset while a write is outstanding and two bytes are queued.
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) strobe(25'(i), 8'($urandom), 1'b0);
    @(negedge clk);
    chk("midrst_pre_ldr_wr", 32'(bus.ldr_wr), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ldr_wr", 32'(bus.ldr_wr), 0);
    chk("midrst_ldr_oe", 32'(bus.ldr_oe), 0);
    chk("midrst_ldr_done", 32'(bus.ldr_done), 0);
    chk("midrst_core_rst_n", 32'(core_rst_n), 0);
    chk("midrst_idx_err", 32'(idx_err), 0);
    exp_q.delete();
    exp_done = '0;
    exp_err  = 1'b0;
    exp_rst  = 1'b0;
    for (int r = 0; r < NR; r++) exp_sum[r] = '0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);

    // Recovery after reset.
    start_dl(8'd3);
    strobe(25'h1ABCDE, 8'h3C, 1'b0);
    strobe(25'h1ABCDF, 8'hC3, 1'b1);
    finish_dl("post_reset");
`ifdef LOADER_CHECKSUM_EN
    chk_sums("csum_post_reset");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
